// File: rtl/de0qsys_pio_out.sv
// Avalon-MM output PIO with DATA/OUTSET/OUTCLEAR and optional timed pulse (`define PIO_OUT_PULSE_EN).
// Latency: out_port updates on the accepting edge, readdata 1 clock; no wait states, never backpressures.
module de0qsys_pio_out #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLR    = 3'd5;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_nxt;
    logic [31:0]      rd_nxt;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

`ifdef PIO_OUT_PULSE_EN
    localparam logic [2:0] A_PLEN   = 3'd2;
    localparam logic [2:0] A_PULSE  = 3'd6;
    localparam logic [2:0] A_STATUS = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [15:0]      pulse_len;
    logic [15:0]      cnt;
    logic [WIDTH-1:0] pulse_mask;
    logic             expire;
    logic             pulse_go;

    assign expire   = (state == BUSY) && (cnt == 16'd1);
    assign pulse_go = wr && (address == A_PULSE) && (pulse_len != 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pulse_mask <= '0;
            pulse_len  <= '0;
        end else begin
            if (wr && address == A_PLEN)
                pulse_len <= writedata[15:0];
            // A retrigger landing on the expiry edge starts a fresh mask
            if (pulse_go) begin
                state      <= BUSY;
                cnt        <= pulse_len;
                pulse_mask <= (expire ? '0 : pulse_mask) | wd;
            end else if (state == BUSY) begin
                cnt <= cnt - 16'd1;
                if (expire) begin
                    state      <= IDLE;
                    pulse_mask <= '0;
                end
            end
        end
    end
`endif

    // Expiry clear first, then the bus write, so a coincident write wins
    always_comb begin
        out_nxt = out_q;
`ifdef PIO_OUT_PULSE_EN
        if (expire)
            out_nxt = out_nxt & ~pulse_mask;
        if (pulse_go)
            out_nxt = out_nxt | wd;
`endif
        if (wr) begin
            case (address)
                A_DATA:  out_nxt = wd;
                A_SET:   out_nxt = out_nxt | wd;
                A_CLR:   out_nxt = out_nxt & ~wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            A_DATA:   rd_nxt[WIDTH-1:0] = out_q;
`ifdef PIO_OUT_PULSE_EN
            A_PLEN:   rd_nxt[15:0]      = pulse_len;
            A_STATUS: rd_nxt[0]         = (state == BUSY);
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_VALUE;
            readdata <= '0;
        end else begin
            out_q    <= out_nxt;
            readdata <= rd_nxt;
        end
    end

    assign out_port = out_q;
endmodule

// File: tb/tb_de0qsys_pio_out.sv
// Bench for de0qsys_pio_out: directed + random bus ops, timeline reference model, queued expectations.
module tb_de0qsys_pio_out;
`ifdef PIO_OUT_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif
    localparam logic [7:0] RV = 8'hA5;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    de0qsys_pio_out #(.WIDTH(8), .RESET_VALUE(RV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic [7:0]  out;
        string       tag;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Reference model: pulse expiry kept as an absolute cycle number
    logic [7:0]  m_out  = RV;
    logic [15:0] m_plen = 16'd0;
    logic [7:0]  m_mask = 8'd0;
    bit          m_busy = 1'b0;
    int          m_exp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_out};
            3'd2:    return PE ? {16'd0, m_plen} : 32'd0;
            3'd7:    return PE ? {31'd0, m_busy} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic op_drive(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] d, input string tag);
        exp_t e;
        int   c;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = d;
        c          = cyc + 1;
        e.due      = c;
        e.tag      = tag;
        e.rd       = model_read(a);
        if (m_busy && c == m_exp) begin
            m_out  = m_out & ~m_mask;
            m_mask = 8'd0;
            m_busy = 1'b0;
        end
        if (cs && !wn) begin
            case (a)
                3'd0: m_out = d[7:0];
                3'd4: m_out = m_out | d[7:0];
                3'd5: m_out = m_out & ~d[7:0];
                3'd2: if (PE) m_plen = d[15:0];
                3'd6: if (PE && m_plen != 16'd0) begin
                    m_out  = m_out | d[7:0];
                    m_mask = m_mask | d[7:0];
                    m_busy = 1'b1;
                    m_exp  = c + int'(m_plen);
                end
                default: ;
            endcase
        end
        e.out = m_out;
        q.push_back(e);
    endtask

    task automatic op(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] d, input string tag);
        @(posedge clk);
        #1;
        op_drive(a, cs, wn, d, tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input string tag);
        op(a, 1'b1, 1'b0, d, tag);
    endtask

    task automatic idle(input int n, input logic [2:0] a, input string tag);
        for (int i = 0; i < n; i++)
            op(a, 1'b0, 1'b1, $urandom, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations never checked", q.size());
            q.delete();
        end
    endtask

    // Asserts reset between edges and checks the asynchronous effect at once
    task automatic reset_pulse(input string tag);
        drain();
        reset_n = 1'b0;
        #1;
        chk({tag, " out_port in reset"}, {24'd0, out_port}, {24'd0, RV});
        chk({tag, " readdata in reset"}, readdata, 32'd0);
        m_out  = RV;
        m_plen = 16'd0;
        m_mask = 8'd0;
        m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                mon_e = q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL stale %s: due cycle %0d, now %0d", mon_e.tag, mon_e.due, cyc);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                mon_e = q.pop_front();
                chk({mon_e.tag, " readdata"}, readdata, mon_e.rd);
                chk({mon_e.tag, " out_port"}, {24'd0, out_port}, {24'd0, mon_e.out});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ra;
        logic        rcs;
        logic        rwn;
        logic [31:0] rd;

        // Power-on reset and first read of DATA
        #1;
        reset_n = 1'b0;
        #1;
        chk("por out_port", {24'd0, out_port}, {24'd0, RV});
        chk("por readdata", readdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        op_drive(3'd0, 1'b0, 1'b1, 32'd0, "rst_read_data");
        idle(1, 3'd7, "rst_read_status");

        // Set / clear and reserved addresses
        wr(3'd0, 32'h0000_000F, "data_0f");
        wr(3'd4, 32'hFFFF_FF30, "outset_30");
        wr(3'd5, 32'h0000_0003, "outclear_03");
        wr(3'd1, 32'hFFFF_FFFF, "wr_rsvd1");
        wr(3'd3, 32'hFFFF_FFFF, "wr_rsvd3");
        idle(1, 3'd4, "rd_outset");
        idle(1, 3'd1, "rd_rsvd1");
        idle(1, 3'd3, "rd_rsvd3");
        idle(1, 3'd0, "rd_data");

        // Single pulse of length 5 on bit 7
        wr(3'd2, 32'hABCD_0005, "plen_5");
        wr(3'd0, 32'h0000_0001, "data_01");
        wr(3'd6, 32'h0000_0080, "pulse_80");
        idle(7, 3'd7, "pulse_status");
        wr(3'd6, 32'h0000_00FF, "pulse_ff");
        idle(2, 3'd2, "rd_plen");

        // Retrigger, then zero-length pulse is ignored
        wr(3'd2, 32'd4, "plen_4");
        wr(3'd0, 32'd0, "data_00");
        wr(3'd6, 32'h01, "pulse_01");
        idle(1, 3'd7, "retrig_gap");
        wr(3'd6, 32'h02, "pulse_02");
        idle(6, 3'd0, "retrig_wait");
        wr(3'd2, 32'd0, "plen_0");
        wr(3'd6, 32'hFF, "pulse_len0");
        idle(2, 3'd0, "len0_wait");

        // OUTSET on the expiry edge wins; PULSE_LEN rewrite mid-pulse ignored
        wr(3'd2, 32'd3, "plen_3");
        wr(3'd6, 32'h80, "pulse_80b");
        wr(3'd2, 32'd9, "plen_9_busy");
        idle(1, 3'd7, "coll_gap");
        wr(3'd4, 32'h80, "outset_on_expiry");
        idle(3, 3'd0, "coll_after");
        wr(3'd6, 32'h40, "pulse_40");
        idle(8, 3'd0, "data_collide_pre");
        wr(3'd0, 32'h40, "data_on_expiry");
        idle(2, 3'd0, "data_collide_post");

        // Reset in the middle of a pulse; first write right after release
        wr(3'd2, 32'd10, "plen_10");
        wr(3'd6, 32'h0C, "pulse_0c");
        idle(2, 3'd7, "busy_before_rst");
        reset_pulse("midpulse");
        op_drive(3'd0, 1'b1, 1'b0, 32'h55, "first_write_after_rst");
        idle(1, 3'd7, "status_after_rst");
        idle(1, 3'd0, "data_after_rst");

        // Random traffic with short pulse lengths
        for (int i = 0; i < 400; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rcs = ($urandom_range(0, 3) != 0);
            rwn = 1'($urandom_range(0, 1));
            rd  = $urandom;
            if (ra == 3'd2)
                rd = (rd & 32'hFFFF_0000) | $urandom_range(0, 7);
            if (i == 200) begin
                reset_pulse("random");
                op_drive(ra, rcs, rwn, rd, "random");
            end else begin
                op(ra, rcs, rwn, rd, "random");
            end
        end
        idle(2, 3'd0, "final");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
